// File: rtl/key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion, one word per clock, into a word RAM.
// Ports: start/key_len/key_in launch a job. busy, done and err report status.
// rk_idx selects a round key; rk_out returns it one cycle later, with rk_valid
// and nr_out alongside. Optional macro KEYSCHED_REV_EN adds rk_rev, which makes
// reads return round key nr_out - rk_idx.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and 0 maps to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = ginv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
          ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end
endmodule

module key_schedule_seq #(
  parameter int MAX_NK = 8,
  parameter int NB     = 4,
  parameter int MAX_NR = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          key_len,
  input  logic [32*MAX_NK-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          nr_out,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk_out,
  output logic                rk_valid
`ifdef KEYSCHED_REV_EN
  ,
  input  logic                rk_rev
`endif
);
  localparam int NW = NB * (MAX_NR + 1);
  localparam int KW = 32 * MAX_NK;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

  state_t      state, nxt;
  logic [31:0] w [NW];
  logic [3:0]  nk, nr;
  logic [5:0]  i;
  logic [2:0]  ph;
  logic [7:0]  rcon;
  logic        go, bad, last;
  logic [3:0]  nk_d;
  logic [5:0]  lastw;

  assign nk_d  = 4'd4 + {1'b0, key_len, 1'b0};
  assign lastw = {nr, 2'b11};
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt  = state;
    go   = 1'b0;
    bad  = 1'b0;
    last = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (key_len == 2'b11) begin
            bad = 1'b1;
          end else begin
            go  = 1'b1;
            nxt = LOAD;
          end
        end
      end
      LOAD: nxt = EXPAND;
      EXPAND: begin
        if (i == lastw) begin
          last = 1'b1;
          nxt  = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  logic [31:0] wprev, wold, sin, sout, temp, wnew;

  assign wprev = w[i - 6'd1];
  assign wold  = w[i - {2'b00, nk}];
  // RotWord only on the rcon step; the Nk=8 mid-step substitutes unrotated.
  assign sin   = (ph == 3'd0) ? {wprev[23:0], wprev[31:24]} : wprev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sin[8*g +: 8]),
      .s (sout[8*g +: 8])
    );
  end

  always_comb begin
    if (ph == 3'd0)
      temp = sout ^ {rcon, 24'h0};
    else if (nk == 4'd8 && ph == 3'd4)
      temp = sout;
    else
      temp = wprev;
    wnew = wold ^ temp;
  end

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (4'(j) < nk) w[j] <= key_in[KW-1-32*j -: 32];
      end
    end else if (state == EXPAND) begin
      w[i] <= wnew;
    end
  end

  logic [3:0]   eidx;
  logic [5:0]   base;
  logic         inr;
  logic [127:0] rd;

`ifdef KEYSCHED_REV_EN
  assign eidx = rk_rev ? (nr_out - rk_idx) : rk_idx;
`else
  assign eidx = rk_idx;
`endif
  assign base = {eidx, 2'b00};
  assign inr  = rk_valid && (rk_idx <= nr_out);

  always_comb begin
    rd = '0;
    if (inr)
      rd = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nk       <= '0;
      nr       <= '0;
      i        <= '0;
      ph       <= '0;
      rcon     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rk_valid <= 1'b0;
      nr_out   <= '0;
      rk_out   <= '0;
    end else begin
      done   <= last;
      err    <= bad;
      rk_out <= rd;
      if (go) begin
        nk       <= nk_d;
        nr       <= nk_d + 4'd6;
        rk_valid <= 1'b0;
      end
      if (bad) rk_valid <= 1'b0;
      if (state == LOAD) begin
        i    <= {2'b00, nk};
        ph   <= '0;
        rcon <= 8'h01;
      end
      if (state == EXPAND) begin
        i  <= i + 6'd1;
        ph <= ({1'b0, ph} == nk - 4'd1) ? 3'd0 : ph + 3'd1;
        if (ph == 3'd0)
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last) begin
          rk_valid <= 1'b1;
          nr_out   <= nr;
        end
      end
    end
  end
endmodule

// File: doc/key_schedule_seq.md
Name: key_schedule_seq

Overview:
- Iterative AES key-schedule engine for AES-128, AES-192 and AES-256; key length is selected at run time, per job.
- Generates one expanded word per clock into an internal word RAM.
- Round keys are read back through a random-access port indexed by round, replacing the flat all-keys output bus.
- Sits between the key register and the encrypt datapath and feeds one 128-bit round key per round.

Parameters:
- MAX_NK, 8: largest key length in 32-bit words; sizes key_in.
- NB, 4: state width in words; fixed by AES.
- MAX_NR, 14: largest round count; word storage is NB*(MAX_NR+1) = 60 words.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin expansion; sampled only in IDLE.
- key_len  in  2  00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = reserved.
- key_in  in  32*MAX_NK  cipher key, MSB-aligned; a 128-bit key occupies [255:128].
- busy  out  1  high in LOAD and EXPAND.
- done  out  1  one-cycle pulse when the last word is written.
- err  out  1  one-cycle pulse when start is given with key_len = 11.
- nr_out  out  4  round count of the stored schedule (10/12/14); 0 after reset.
- rk_idx  in  4  round-key index to read.
- rk_out  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
- rk_valid  out  1  high while a complete schedule is stored.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state returns to IDLE; busy, done, err, rk_valid, nr_out and rk_out all go to 0.
  - This applies mid-expansion too; the partial schedule is discarded.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE:
  - start = 1 with a valid key_len: latch Nk (4/6/8) and Nr (Nk+6), clear rk_valid, go to LOAD.
  - start = 1 with key_len = 11: pulse err, clear rk_valid, stay in IDLE.
- LOAD (1 cycle):
  - write w[0..Nk-1] from key_in (w[0] = key_in[255:224]).
  - set i = Nk, rcon = 0x01, then go to EXPAND.
- EXPAND (one word per cycle):
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon), i.e. ×2 in GF(2^8) with 0x11b reduction.
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - When i == 4*(Nr+1)-1: write the word, pulse done, set rk_valid = 1 and nr_out = Nr, go to IDLE.
- SubWord uses the existing encrypt-path S-box module, 4 instances.
- i mod Nk is tracked with a wrap counter, not a divider.
- Latency, from the start edge to the done pulse:
  - 128-bit: 1 + 40 = 41 cycles.
  - 192-bit: 1 + 46 = 47 cycles.
  - 256-bit: 1 + 52 = 53 cycles.
- start while busy is ignored; there is no queueing.
- Read port:
  - rk_out is registered, one cycle after rk_idx.
  - rk_out is 0 when rk_valid = 0 or rk_idx > nr_out.
- A new job clears rk_valid at its start edge; the old schedule is not readable during re-expansion.

Optional Feature:
- Macro: KEYSCHED_REV_EN.
- When defined:
  - adds input rk_rev (1 bit).
  - With rk_rev = 1, the read port returns round key nr_out - rk_idx, for decryption ordering.
  - Range check and latency are unchanged.
- When undefined: the port is absent and reads are always forward order.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done occurs 41 cycles after start.
  - rk_idx = 1 reads a0fafe1788542cb123a339392a6c7605.
  - rk_idx = 10 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
  - nr_out = 10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done occurs after 47 cycles.
  - rk_idx = 12 reads e98ba06f448c773c8ecc720401002202.
  - nr_out = 12.
- AES-256, key 603deb10...0914dff4 (FIPS-197 A.3):
  - done occurs after 53 cycles.
  - w[8] = 9ba35411.
  - rk_idx = 14 reads fe4890d1e6188d0b046df344706c631e.
- Boundaries:
  - key_len = 11 with start gives an err pulse; busy stays 0 and rk_valid goes to 0.
  - rk_idx = 11 after an AES-128 job reads 0.
  - start pulsed while busy has no effect on the done timing.
- Reset mid-operation:
  - drive rst_n = 0 for 1 cycle at cycle 20 of an AES-256 job; busy = 0, rk_valid = 0 and no done pulse follows.
  - A restarted AES-128 job then gives the correct round key 10.
- With KEYSCHED_REV_EN and AES-128: rk_rev = 1, rk_idx = 0 reads d014f9a8c9ee2589e13f0cc8b6630ca6.
